// File: rtl/wb_initiator.sv
// Wishbone classic initiator: takes one command over a valid/ready port,
// runs a single bus cycle with an ack timeout, then holds the response until consumed.
module wb_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        wb_clock_i,
  input  logic        wb_reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  // Last wait count before giving up: TIMEOUT bus cycles in total.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_ack_seen;
  logic        w_timeout;
  logic        w_rsp_done;

  logic [7:0]  r_wait_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_sel;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering between blocks is irrelevant.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_seen  = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack wins over a timeout landing on the same cycle.
        if (wb_ack_i) begin
          w_ack_seen  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_wait_cnt == LP_LAST_WAIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      r_wait_cnt <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_sel      <= 4'd0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= req_we_i;
        r_addr     <= req_addr_i;
        r_data     <= req_data_i;
        r_sel      <= req_sel_i;
        r_wait_cnt <= 8'd0;
      end else if (r_state == ST_BUS && !wb_ack_i) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (w_ack_seen) begin
        r_rsp_data <= r_we ? 32'd0 : wb_data_i;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'd0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  // All handshake and bus controls decode the registered state only.
  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign wb_cyc_o    = (r_state == ST_BUS);
  assign wb_strobe_o = (r_state == ST_BUS);
  assign wb_we_o     = r_we;
  assign wb_addr_o   = r_addr;
  assign wb_data_o   = r_data;
  assign wb_sel_o    = r_sel;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: a transaction-level model checked every cycle,
// plus literal expectations for cycle counts and response contents.
module tb_wb_initiator;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        wb_reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  wb_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clock_i  (clk),
    .wb_reset_i  (wb_reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_we_o     (wb_we_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_sel_o    (wb_sel_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding command, bus phase lasting until
  // ack or TIMEOUT cycles, response held until taken. Inputs are sampled at the
  // falling edge, which is what the DUT sees on the following rising edge.
  bit          m_ok = 1'b0;
  bit          m_bus, m_rsp, m_err, m_we;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_sel;
  int          m_waited;

  always @(negedge clk) begin
    if (m_ok) begin
      check("req_ready", {31'd0, req_ready_o}, {31'd0, !m_bus && !m_rsp});
      check("wb_cyc", {31'd0, wb_cyc_o}, {31'd0, m_bus});
      check("wb_stb", {31'd0, wb_strobe_o}, {31'd0, m_bus});
      check("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_rsp});
      if (m_bus) begin
        check("wb_we", {31'd0, wb_we_o}, {31'd0, m_we});
        check("wb_addr", wb_addr_o, m_addr);
        check("wb_sel", {28'd0, wb_sel_o}, {28'd0, m_sel});
        if (m_we) check("wb_data", wb_data_o, m_wdata);
      end
      if (m_rsp) begin
        check("rsp_data", rsp_data_o, m_rdata);
        check("rsp_err", {31'd0, rsp_err_o}, {31'd0, m_err});
      end
    end
    if (wb_reset_i) begin
      m_ok = 1'b1; m_bus = 1'b0; m_rsp = 1'b0; m_err = 1'b0; m_we = 1'b0;
      m_rdata = '0; m_addr = '0; m_wdata = '0; m_sel = '0; m_waited = 0;
    end else if (m_bus) begin
      m_waited++;
      if (wb_ack_i) begin
        m_bus = 1'b0; m_rsp = 1'b1; m_err = 1'b0;
        m_rdata = m_we ? 32'd0 : wb_data_i;
      end else if (m_waited == TIMEOUT) begin
        m_bus = 1'b0; m_rsp = 1'b1; m_err = 1'b1; m_rdata = '0;
      end
    end else if (m_rsp) begin
      if (rsp_ready_i) m_rsp = 1'b0;
    end else if (req_valid_i) begin
      m_bus = 1'b1; m_waited = 0;
      m_we = req_we_i; m_addr = req_addr_i; m_wdata = req_data_i; m_sel = req_sel_i;
    end
  end

  // Snapshot of the bus outputs in the first bus cycle of the last transaction.
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;

  // One full transaction. ack_at: bus-cycle index carrying the ack (-1: never).
  // hold: cycles the response is back-pressured, with stray acks driven meanwhile.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                     input int hold, output int n_bus, output logic [31:0] r_d,
                     output logic r_e);
    int guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("ready_before_req", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = data; req_sel_i = sel;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_data_i = 32'h0; req_addr_i = 32'h0;
    s_we = wb_we_o; s_addr = wb_addr_o; s_wdata = wb_data_o; s_sel = wb_sel_o;
    n_bus = 0;
    while (wb_cyc_o && n_bus < 300) begin
      wb_ack_i  = (n_bus == ack_at);
      wb_data_i = (n_bus == ack_at) ? rdata : (32'h0BAD_0000 | 32'(n_bus));
      @(posedge clk); #1;
      n_bus++;
    end
    wb_ack_i = 1'b0;
    r_d = rsp_data_o;
    r_e = rsp_err_o;
    check("rsp_valid_after_bus", {31'd0, rsp_valid_o}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      wb_ack_i = 1'b1; wb_data_i = 32'h5555_5555;
      @(posedge clk); #1;
    end
    wb_ack_i = 1'b0;
    if (hold > 0) begin
      check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp_rsp_data", rsp_data_o, r_d);
      check("bp_no_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check("ready_after_hs", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    int          nb;
    logic [31:0] d;
    logic        e;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_addr", wb_addr_o, 32'd0);
    check("rst_wdata", wb_data_o, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    wb_reset_i = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

    // Read, ack after two wait cycles.
    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 0, nb, d, e);
    check("rd_bus_cycles", 32'(nb), 32'd3);
    check("rd_data", d, 32'hDEAD_BEEF);
    check("rd_err", {31'd0, e}, 32'd0);

    // Write, immediate ack; responder data must not leak into the response.
    txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'h1, 0, 32'h1234_5678, 0, nb, d, e);
    check("wr_bus_cycles", 32'(nb), 32'd1);
    check("wr_we", {31'd0, s_we}, 32'd1);
    check("wr_addr", s_addr, 32'h3000_0000);
    check("wr_wdata", s_wdata, 32'h0000_00A5);
    check("wr_sel", {28'd0, s_sel}, 32'h1);
    check("wr_rsp_data", d, 32'd0);
    check("wr_err", {31'd0, e}, 32'd0);

    // Timeout, responder never acks.
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 32'h0, 0, nb, d, e);
    check("to_bus_cycles", 32'(nb), 32'd16);
    check("to_err", {31'd0, e}, 32'd1);
    check("to_data", d, 32'd0);

    // Back-pressured response with stray acks in RESP.
    txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 0, 32'hCAFE_F00D, 5, nb, d, e);
    check("bp_data", d, 32'hCAFE_F00D);

    // Ack on the cycle the timeout would fire: success wins.
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, TIMEOUT - 1, 32'h0123_4567, 0, nb, d, e);
    check("ackto_bus_cycles", 32'(nb), 32'd16);
    check("ackto_err", {31'd0, e}, 32'd0);
    check("ackto_data", d, 32'h0123_4567);

    // Stray ack while idle.
    wb_ack_i = 1'b1; wb_data_i = 32'hFFFF_0000;
    repeat (4) @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    check("stray_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("stray_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("stray_ready", {31'd0, req_ready_o}, 32'd1);

    // Back-to-back writes.
    txn(1'b1, 32'h4000_0000, 32'hAAAA_5555, 4'hC, 1, 32'h0, 0, nb, d, e);
    check("b2b0_bus_cycles", 32'(nb), 32'd2);
    txn(1'b1, 32'h4000_0004, 32'h5555_AAAA, 4'h6, 0, 32'h0, 0, nb, d, e);
    check("b2b1_addr", s_addr, 32'h4000_0004);

    // Reset during the bus wait: no response, idle afterwards.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h5000_0000; req_sel_i = 4'hF;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_cyc_before_rst", {31'd0, wb_cyc_o}, 32'd1);
    wb_reset_i = 1'b1;
    @(posedge clk); #1;
    wb_reset_i = 1'b0;
    check("mid_cyc_after_rst", {31'd0, wb_cyc_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    check("mid_ready", {31'd0, req_ready_o}, 32'd1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
